muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit. It sits in the EX stage beside the ALU.
- Performs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU at one bit per cycle over an XLEN-wide datapath.
- busy_o feeds the hazard unit, which freezes PC, IF/ID and ID/EX while an operation is in flight.
- The result returns to EX/MEM with its destination register tag.

---
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with sign correction in a dedicated FIX state.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] rd_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] rd_o
);

  localparam int unsigned     CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  // Captured operation
  logic [2:0]       op;
  logic [TAG_W-1:0] tag;
  logic             neg;
  logic [CW-1:0]    cnt;
  logic [XLEN-1:0]  mag_a;
  logic [XLEN-1:0]  mag_b;

  // Iteration registers
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo;

  // Request decode
  logic            accept;
  logic            a_signed, b_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            req_neg;

  // Iteration step values
  logic [XLEN:0]   mul_addend, mul_sum;
  logic [XLEN:0]   div_shift, div_diff;

  // Final correction values
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);
  assign accept  = valid_i && ready_o && !flush_i;

  // Decode the incoming request: signedness, magnitudes, special divide cases
  always_comb begin
    a_signed    = (funct3_i == OP_MULH) || (funct3_i == OP_MULHSU) ||
                  (funct3_i == OP_DIV)  || (funct3_i == OP_REM);
    b_signed    = (funct3_i == OP_MULH) || (funct3_i == OP_DIV) ||
                  (funct3_i == OP_REM);
    sign_a      = a_signed && rs1_i[XLEN-1];
    sign_b      = b_signed && rs2_i[XLEN-1];
    a_abs       = sign_a ? -rs1_i : rs1_i;
    b_abs       = sign_b ? -rs2_i : rs2_i;
    // Remainder takes the dividend's sign; product and quotient the xor
    req_neg     = (funct3_i[2] && funct3_i[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero    = (rs2_i == '0);
    div_ovf     = !funct3_i[0] && (rs1_i == MOST_NEG) && (rs2_i == '1);
    special     = funct3_i[2] && (div_zero || div_ovf);
    special_res = '0;
    if (div_zero) begin
      special_res = funct3_i[1] ? rs1_i : '1;
    end else if (div_ovf) begin
      special_res = funct3_i[1] ? '0 : rs1_i;
    end
  end

  // One-bit step values for the shift-add multiply and restoring divide
  always_comb begin
    mul_addend = prod[0] ? {1'b0, mag_a} : '0;
    mul_sum    = {1'b0, prod[2*XLEN-1:XLEN]} + mul_addend;
    div_shift  = {rem[XLEN-1:0], quo[XLEN-1]};
    div_diff   = div_shift - {1'b0, mag_b};
  end

  // Sign correction and half / quotient / remainder selection
  always_comb begin
    prod_fix = neg ? -prod : prod;
    quo_fix  = neg ? -quo : quo;
    rem_fix  = neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    if (op[2]) begin
      fix_res = op[1] ? rem_fix : quo_fix;
    end else if (op == OP_MUL) begin
      fix_res = prod_fix[XLEN-1:0];
    end else begin
      fix_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush_i) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = flush_i ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, register result from FIX
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op       <= '0;
      tag      <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op    <= funct3_i;
            tag   <= rd_i;
            neg   <= req_neg;
            cnt   <= '0;
            mag_a <= a_abs;
            mag_b <= b_abs;
            // Multiplier sits in the low half and shifts out as the product grows
            prod  <= {{XLEN{1'b0}}, b_abs};
            rem   <= '0;
            quo   <= a_abs;
            if (special) begin
              result_o <= special_res;
              rd_o     <= rd_i;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op[2]) begin
            if (!div_diff[XLEN]) begin
              rem <= div_diff;
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= div_shift;
              quo <= {quo[XLEN-2:0], 1'b0};
            end
          end else begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end
        end
        FIX: begin
          if (!flush_i) begin
            result_o <= fix_res;
            rd_o     <= tag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
